write_back_arbiter: RTL and testbench

- Shares the register file's single write-back path among NUM_REQ functional units, using round-robin arbitration.
- Sequences the per-register write_reserve and write_back strobes so that no result is lost.
- Sits between the execution units and the register file. Decode also issues reservations through this block.

---
 rtl/write_back_arbiter_pkg.sv | 29 ++
 rtl/write_back_arbiter_rr.sv | 33 +++
 rtl/write_back_arbiter.sv | 129 ++++++++++++
 tb/tb_write_back_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/write_back_arbiter_pkg.sv
// Register-file parameters shared by the write-back path and its users.
// No logic of its own; types and a one-hot helper only.
// Not applicable (no handshakes live here).
package register_params;

   localparam int OPERAND_WIDTH  = 32;
   localparam int NUM_REGS       = 16;
   localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);
   localparam int NUM_WB_REQ     = 4;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [OPERAND_WIDTH-1:0]  operand_t;
   typedef logic [NUM_REGS-1:0]       reg_mask_t;

   // One functional-unit result as it travels toward the register file.
   typedef struct packed {
      reg_addr_t addr;
      operand_t  data;
   } wb_req_t;

   // Decode a register index into a per-cell strobe vector.
   function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
      reg_mask_t mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/write_back_arbiter_rr.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Purely combinational, zero cycles.
// No backpressure; an all-zero request vector yields an all-zero grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   int   idx;
   logic found;

   // Walk the requesters starting at ptr and stop at the first one asking.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/write_back_arbiter.sv
// Shares the register file's single write-back port among NUM_REQ units, round robin.
// One cycle: handshake in t drives write_back/wb_data in t+1; reservations alike.
// One grant per cycle; a unit colliding with a same-cycle reservation waits a turn.
module write_back_arbiter
   import register_params::*;
#(
   parameter int NUM_REQ = NUM_WB_REQ
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*OPERAND_WIDTH-1:0]  req_data,
   input  logic                              rsv_valid,
   output logic                              rsv_ready,
   input  logic [REG_ADDR_WIDTH-1:0]         rsv_addr,
   input  logic [NUM_REGS-1:0]               reserve_status,
   output logic [NUM_REGS-1:0]               write_reserve,
   output logic [NUM_REGS-1:0]               write_back,
   output logic [OPERAND_WIDTH-1:0]          wb_data,
   output logic                              err_unreserved
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic               rsv_accept;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_ptr_next;
   logic               handshake;
   logic               target_reserved;
   wb_req_t            sel;

   // Decode waits while the target is still reserved, so a second writer cannot overtake.
   always_comb begin
      rsv_accept = rst & rsv_valid & ~reserve_status[rsv_addr];
   end

   assign rsv_ready = rsv_accept;

   // A cell favours reserve over write-back, so a unit writing the register being
   // reserved this very cycle is held off rather than silently lost.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] &
                       ~(rsv_accept &
                         (rsv_addr == req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]));
      end
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (PTR_W)
   ) u_rr (
      .req       (eligible),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant & {NUM_REQ{rst}};
   assign handshake = |req_ready;

   // Pick the granted unit's result with an AND-OR mux keyed on the one-hot grant.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel.addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            sel.data = req_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
         end
      end
   end

   // Pointer moves just past the winner so every unit gets a turn.
   always_comb begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
         rr_ptr_next = '0;
      end else begin
         rr_ptr_next = grant_idx + PTR_W'(1);
      end
   end

   assign target_reserved = reserve_status[sel.addr];

   // Round-robin pointer: advances only on a completed handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= rr_ptr_next;
      end
   end

   // Reserve strobe: single-cycle pulse the cycle after the reservation is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_reserve <= '0;
      end else begin
         write_reserve <= rsv_accept ? reg_onehot(rsv_addr) : '0;
      end
   end

   // Write-back strobe and error pulse; a result for an unreserved register is
   // consumed and dropped, flagged instead of being written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_back     <= '0;
         err_unreserved <= 1'b0;
      end else begin
         write_back     <= (handshake && target_reserved) ? reg_onehot(sel.addr) : '0;
         err_unreserved <= handshake & ~target_reserved;
      end
   end

   // Shared data bus: loads on a handshake and otherwise holds its last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_data <= '0;
      end else if (handshake) begin
         wb_data <= sel.data;
      end
   end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Randomized bench for write_back_arbiter against a cycle-level reference model.
// Model state: round-robin turn counter, expected strobes, emulated register-file reserve bits.
// Inputs change one time unit after the rising edge; outputs are checked away from it.
module tb_write_back_arbiter;
   import register_params::*;

   localparam int N = NUM_WB_REQ;
   localparam int W = REG_ADDR_WIDTH;
   localparam int D = OPERAND_WIDTH;
   localparam int R = NUM_REGS;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_addr;
   logic [N*D-1:0] req_data;
   logic           rsv_valid;
   logic           rsv_ready;
   logic [W-1:0]   rsv_addr;
   logic [R-1:0]   reserve_status;
   logic [R-1:0]   write_reserve;
   logic [R-1:0]   write_back;
   logic [D-1:0]   wb_data;
   logic           err_unreserved;

   write_back_arbiter #(.NUM_REQ(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .rsv_valid      (rsv_valid),
      .rsv_ready      (rsv_ready),
      .rsv_addr       (rsv_addr),
      .reserve_status (reserve_status),
      .write_reserve  (write_reserve),
      .write_back     (write_back),
      .wb_data        (wb_data),
      .err_unreserved (err_unreserved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state.
   int           turn;
   logic [R-1:0] cells;
   logic [R-1:0] exp_wb;
   logic [R-1:0] exp_wr;
   logic [D-1:0] exp_data;
   logic         exp_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      turn     = 0;
      exp_wb   = '0;
      exp_wr   = '0;
      exp_data = '0;
      exp_err  = 1'b0;
   endtask

   task automatic set_req(input int i, input logic v, input int a, input logic [D-1:0] d);
      req_valid[i]       = v;
      req_addr[i*W +: W] = W'(a);
      req_data[i*D +: D] = d;
   endtask

   task automatic drive_random();
      int j;
      for (int i = 0; i < N; i++) begin
         set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, R - 1), $urandom);
      end
      rsv_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
         j        = $urandom_range(0, N - 1);
         rsv_addr = req_addr[j*W +: W];
      end else begin
         rsv_addr = W'($urandom_range(0, R - 1));
      end
      reserve_status = cells;
   endtask

   // One clock cycle: predict from the current inputs, then check both the
   // combinational handshake outputs and the registered strobes that follow.
   task automatic step();
      logic         acc;
      int           g;
      int           i;
      logic [W-1:0] a;
      logic [N-1:0] want_ready;
      logic [R-1:0] nwb;
      logic [R-1:0] nwr;
      logic [D-1:0] ndata;
      logic         nerr;

      @(negedge clk);
      acc = rsv_valid && !reserve_status[rsv_addr];
      g   = -1;
      for (int k = 0; k < N; k++) begin
         i = (turn + k) % N;
         if (g < 0 && req_valid[i] && !(acc && rsv_addr == req_addr[i*W +: W])) g = i;
      end
      want_ready = '0;
      if (g >= 0) want_ready[g] = 1'b1;
      check("req_ready", req_ready, want_ready);
      check("rsv_ready", rsv_ready, acc);

      nwr = '0;
      if (acc) nwr[rsv_addr] = 1'b1;
      nwb   = '0;
      nerr  = 1'b0;
      ndata = exp_data;
      if (g >= 0) begin
         a     = req_addr[g*W +: W];
         ndata = req_data[g*D +: D];
         if (reserve_status[a]) nwb[a] = 1'b1;
         else nerr = 1'b1;
         turn = (g + 1) % N;
      end

      @(posedge clk);
      #1;
      // Register cells capture the strobes that were live in the cycle just ended.
      for (int r = 0; r < R; r++) begin
         if (exp_wr[r]) cells[r] = 1'b1;
         else if (exp_wb[r]) cells[r] = 1'b0;
      end
      exp_wb   = nwb;
      exp_wr   = nwr;
      exp_data = ndata;
      exp_err  = nerr;
      check("write_back", write_back, exp_wb);
      check("write_reserve", write_reserve, exp_wr);
      check("wb_data", wb_data, exp_data);
      check("err_unreserved", err_unreserved, exp_err);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      cells     = '1;
      cells[0]  = 1'b0;
      model_reset();

      // Everything asking while reset is held: nothing may be granted or strobed.
      for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 3, 32'h1000 + i);
      rsv_valid      = 1'b1;
      rsv_addr       = '0;
      reserve_status = cells;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsv_ready", rsv_ready, 0);
      check("rst_write_back", write_back, 0);
      check("rst_write_reserve", write_reserve, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_err", err_unreserved, 0);

      // Release: requester 0 wins first, its strobe follows a cycle later.
      rst = 1'b1;
      step();
      rsv_valid = 1'b0;
      step();
      repeat (4) step();

      // Long randomized run.
      repeat (3000) begin
         drive_random();
         step();
      end

      // Unreserved target: consumed, no strobe, one-cycle error pulse.
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, '0);
      set_req(2, 1'b1, 9, 32'hDEADBEEF);
      rsv_valid      = 1'b0;
      cells[9]       = 1'b0;
      reserve_status = cells;
      step();
      set_req(2, 1'b0, 9, '0);
      step();
      step();

      // Reset landing right after a handshake wipes the pending strobe.
      set_req(2, 1'b1, 9, 32'hCAFEF00D);
      cells[9]       = 1'b1;
      reserve_status = cells;
      step();
      #1;
      rst = 1'b0;
      #1;
      check("midrst_write_back", write_back, 0);
      check("midrst_wb_data", wb_data, 0);
      check("midrst_err", err_unreserved, 0);
      check("midrst_req_ready", req_ready, 0);
      model_reset();
      set_req(2, 1'b0, 9, '0);
      @(posedge clk);
      #1;
      check("inrst_write_back", write_back, 0);
      rst = 1'b1;
      step();
      step();

      // Short randomized tail after the second reset.
      repeat (300) begin
         drive_random();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
